// File: rtl/mult_pkg.sv
// Shared definitions for the 64x64 multiplier datapath and its consumers:
// the default product width and the accumulator FSM state encoding.
package mult_pkg;

    // Width of a full 64x64 unsigned product.
    localparam int unsigned PROD_W_DEF = 128;

    // Accumulator FSM: no open group, or a group in progress.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/product_adder_sat.sv
// Combinational ACC_W-bit unsigned adder with carry out.
// Build option: ACC_SATURATE_EN clamps the sum to all-ones on carry out.
// Without it the sum wraps modulo 2^ACC_W.
module product_adder_sat #(
    parameter int unsigned ACC_W = 136
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full_s;

    // Full-width add, then wrap or clamp depending on the build option.
    always_comb begin
        full_s  = {1'b0, a_i} + {1'b0, b_i};
        carry_o = full_s[ACC_W];
`ifdef ACC_SATURATE_EN
        if (full_s[ACC_W]) begin
            sum_o = {ACC_W{1'b1}};
        end else begin
            sum_o = full_s[ACC_W-1:0];
        end
`else
        sum_o = full_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of unsigned products from the non-stallable multiplier and
// presents each group total on a valid/ready output register. Results that
// cannot be stored because the output is still held are dropped and flagged
// by the sticky err_drop. Build option ACC_SATURATE_EN (see product_adder_sat).
module product_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = PROD_W + 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    input  logic              prod_last,
    input  logic [PROD_W-1:0] product,
    input  logic              acc_clr,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_sum,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf,
    output logic              err_drop
);

    // Group state
    acc_state_e        state_q,  state_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              ovf_q,    ovf_d;

    // Output register
    logic              valid_q,  valid_d;
    logic [ACC_W-1:0]  sum_q,    sum_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              rovf_q,   rovf_d;
    logic              drop_q,   drop_d;

    // Datapath
    logic [ACC_W-1:0]  base_acc_s;
    logic [CNT_W-1:0]  base_cnt_s;
    logic              base_ovf_s;
    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  add_sum_s;
    logic              add_carry_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              grp_ovf_s;
    logic              beat_s;
    logic              complete_s;
    logic              load_s;
    logic              drop_s;

    // A beat in IDLE starts from zero; in ACCUM it extends the open group.
    always_comb begin
        if (state_q == ST_ACCUM) begin
            base_acc_s = acc_q;
            base_cnt_s = cnt_q;
            base_ovf_s = ovf_q;
        end else begin
            base_acc_s = {ACC_W{1'b0}};
            base_cnt_s = {CNT_W{1'b0}};
            base_ovf_s = 1'b0;
        end
        prod_ext_s = {{(ACC_W-PROD_W){1'b0}}, product};
    end

    product_adder_sat #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a_i     (base_acc_s),
        .b_i     (prod_ext_s),
        .sum_o   (add_sum_s),
        .carry_o (add_carry_s)
    );

    // Saturating term count, sticky overflow, and beat/completion qualifiers.
    always_comb begin
        if (base_cnt_s == {CNT_W{1'b1}}) begin
            cnt_inc_s = base_cnt_s;
        end else begin
            cnt_inc_s = base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        grp_ovf_s  = base_ovf_s | add_carry_s;
        beat_s     = prod_valid & ~acc_clr;
        complete_s = beat_s & prod_last;
        load_s     = complete_s & (~valid_q | acc_ready);
        drop_s     = complete_s & valid_q & ~acc_ready;
    end

    // Group FSM next state: clear has priority, completion returns to IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (acc_clr || complete_s) begin
            state_d = ST_IDLE;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
        end else if (beat_s) begin
            state_d = ST_ACCUM;
            acc_d   = add_sum_s;
            cnt_d   = cnt_inc_s;
            ovf_d   = grp_ovf_s;
        end else begin
            state_d = state_q;
        end
    end

    // Output register next state: load, drop, or release on handshake.
    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        count_d = count_q;
        rovf_d  = rovf_q;
        drop_d  = drop_q | drop_s;
        if (load_s) begin
            valid_d = 1'b1;
            sum_d   = add_sum_s;
            count_d = cnt_inc_s;
            rovf_d  = grp_ovf_s;
        end else if (valid_q && acc_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= {ACC_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            rovf_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            rovf_q  <= rovf_d;
            drop_q  <= drop_d;
        end
    end

    assign acc_valid = valid_q;
    assign acc_sum   = sum_q;
    assign acc_count = count_q;
    assign acc_ovf   = rovf_q;
    assign err_drop  = drop_q;

endmodule
